// File: rtl/repeater_bank_pkg.sv
// Shared redstone timing definitions: default delay width, code-to-ticks mapping, tick-enable level.
// Pure definitions, no latency or flow control.
package repeater_bank_pkg;

  localparam int DEFAULT_DELAY_W = 2;

  // Level of the game-tick enable on which redstone state advances.
  localparam logic TICK_ACTIVE = 1'b1;

  function automatic int delay_ticks(input int code);
    return code + 1;
  endfunction

endpackage

// File: rtl/repeater_cell.sv
// One redstone repeater channel with selectable delay, lock and minimum-pulse extension.
// Latency D = code+1 ticks inclusive of the sampling tick; no backpressure, advances only on ticks.
module repeater_cell
  import repeater_bank_pkg::*;
#(
  parameter int   DELAY_W = DEFAULT_DELAY_W,
  parameter logic INIT    = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_in,
  input  logic               i_lock,
  input  logic [DELAY_W-1:0] i_delay,
  output logic               o_out,
  output logic               o_busy
);

  logic               target;
  logic [DELAY_W-1:0] count;
  int                 d_ticks;

  assign d_ticks = delay_ticks(int'(i_delay));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_out  <= INIT;
      o_busy <= 1'b0;
      target <= INIT;
      count  <= '0;
    end else if (i_tick == TICK_ACTIVE) begin
      if (i_lock) begin
        o_busy <= 1'b0;
      end else if (o_busy) begin
        // Input is ignored while busy, which stretches short pulses to D ticks.
        if (count == '0) begin
          o_out  <= target;
          o_busy <= 1'b0;
        end else begin
          count <= count - DELAY_W'(1);
        end
      end else if (i_in != o_out) begin
        if (d_ticks == 1) begin
          o_out <= i_in;
        end else begin
          o_busy <= 1'b1;
          target <= i_in;
          count  <= DELAY_W'(d_ticks - 2);
        end
      end
    end
  end

endmodule

// File: rtl/repeater_bank.sv
// Bank of independent redstone repeaters sharing one clock and one tick enable.
// Latency per channel D = code+1 ticks; no backpressure, outputs registered.
module repeater_bank
  import repeater_bank_pkg::*;
#(
  parameter int                  CHANNELS   = 8,
  parameter int                  DELAY_W    = DEFAULT_DELAY_W,
  parameter logic [CHANNELS-1:0] INIT_STATE = {CHANNELS{1'b0}}
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_tick,
  input  logic [CHANNELS-1:0]           i_in,
  input  logic [CHANNELS-1:0]           i_lock,
  input  logic [CHANNELS*DELAY_W-1:0]   i_delay,
  output logic [CHANNELS-1:0]           o_out,
  output logic [CHANNELS-1:0]           o_busy
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_cell
    repeater_cell #(
      .DELAY_W (DELAY_W),
      .INIT    (INIT_STATE[c])
    ) u_cell (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_tick  (i_tick),
      .i_in    (i_in[c]),
      .i_lock  (i_lock[c]),
      .i_delay (i_delay[c*DELAY_W +: DELAY_W]),
      .o_out   (o_out[c]),
      .o_busy  (o_busy[c])
    );
  end

endmodule

// File: tb/tb_repeater_bank.sv
// Self-checking bench for repeater_bank: directed test-plan steps plus randomized traffic vs. a reference model.
module tb_repeater_bank;

  localparam int            CH   = 8;
  localparam int            DW   = 2;
  localparam logic [CH-1:0] INIT = 8'hA5;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_tick;
  logic [CH-1:0]      i_in;
  logic [CH-1:0]      i_lock;
  logic [CH*DW-1:0]   i_delay;
  logic [CH-1:0]      o_out;
  logic [CH-1:0]      o_busy;

  repeater_bank #(
    .CHANNELS   (CH),
    .DELAY_W    (DW),
    .INIT_STATE (INIT)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_tick  (i_tick),
    .i_in    (i_in),
    .i_lock  (i_lock),
    .i_delay (i_delay),
    .o_out   (o_out),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each pending change is scheduled at an absolute tick number.
  bit m_out  [CH];
  bit m_pend [CH];
  bit m_val  [CH];
  int m_due  [CH];
  int tick_no = 0;

  function automatic logic [CH-1:0] exp_out();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = m_out[c];
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_busy();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = m_pend[c];
    return v;
  endfunction

  task automatic model_edge();
    logic [CH-1:0] init_v;
    logic [DW-1:0] code;
    int            d;
    init_v = INIT;
    if (i_rst) begin
      for (int c = 0; c < CH; c++) begin
        m_out[c]  = init_v[c];
        m_pend[c] = 1'b0;
      end
    end else if (i_tick) begin
      for (int c = 0; c < CH; c++) begin
        code = i_delay[c*DW +: DW];
        d    = int'(code) + 1;
        if (i_lock[c]) begin
          m_pend[c] = 1'b0;
        end else if (m_pend[c]) begin
          if (tick_no == m_due[c]) begin
            m_out[c]  = m_val[c];
            m_pend[c] = 1'b0;
          end
        end else if (i_in[c] != m_out[c]) begin
          if (d == 1) begin
            m_out[c] = i_in[c];
          end else begin
            m_pend[c] = 1'b1;
            m_val[c]  = i_in[c];
            m_due[c]  = tick_no + d - 1;
          end
        end
      end
      tick_no++;
    end
  endtask

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge i_clk);
    model_edge();
    #1;
    chk("model_out", o_out, exp_out());
    chk("model_busy", o_busy, exp_busy());
  endtask

  logic [DW-1:0] codes [CH];

  initial begin
    i_rst   = 1'b1;
    i_tick  = 1'b1;
    i_in    = '0;
    i_lock  = '0;
    i_delay = '1;

    // Reset loads INIT; the next tick starts a countdown on every high channel.
    clk_step();
    chk("reset_out", o_out, 8'hA5);
    chk("reset_busy", o_busy, 8'h00);
    i_rst = 1'b0;
    clk_step();
    chk("post_reset_busy", o_busy, 8'hA5);
    chk("post_reset_out", o_out, 8'hA5);
    repeat (4) clk_step();
    chk("settled_out", o_out, 8'h00);
    chk("settled_busy", o_busy, 8'h00);

    codes = '{0: 2'd2, 1: 2'd3, 2: 2'd1, 3: 2'd2, 4: 2'd3, default: 2'd0};
    for (int c = 0; c < CH; c++) i_delay[c*DW +: DW] = codes[c];

    // Ch0 D=3 rise, ch1 D=4 one-tick pulse, ch3 D=3 rise interrupted by lock.
    i_in = 8'b0000_1011;
    for (int e = 0; e < 10; e++) begin
      i_in[1]   = (e == 0);
      i_lock[3] = (e >= 1 && e <= 5);
      clk_step();
      chk_bit("ch0_out", o_out[0], e >= 2);
      chk_bit("ch0_busy", o_busy[0], e < 2);
      chk_bit("ch1_out", o_out[1], e >= 3 && e <= 6);
      chk_bit("ch3_out", o_out[3], e >= 8);
      chk_bit("ch3_busy", o_busy[3], e == 0 || e == 6 || e == 7);
    end

    // Ch2 D=2 with the tick enable on every third clock only.
    i_in[2] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      i_tick = (k % 3 == 0);
      clk_step();
      chk_bit("ch2_out", o_out[2], k >= 3);
      chk_bit("ch2_busy", o_busy[2], k < 3);
    end
    i_tick = 1'b1;

    // Ch4 D=4 reset mid-countdown drops the pending change.
    i_in[4] = 1'b1;
    clk_step();
    clk_step();
    chk_bit("ch4_busy_pre", o_busy[4], 1'b1);
    i_rst = 1'b1;
    i_in  = INIT;
    clk_step();
    chk("ch4_rst_out", o_out, 8'hA5);
    chk("ch4_rst_busy", o_busy, 8'h00);
    i_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      clk_step();
      chk_bit("ch4_no_change", o_out[4], 1'b0);
    end

    // Randomized traffic: delay changes mid-flight, sparse locks and resets, gapped ticks.
    for (int k = 0; k < 3000; k++) begin
      i_in    = CH'($urandom);
      i_lock  = CH'($urandom) & CH'($urandom) & CH'($urandom);
      i_delay = (CH*DW)'($urandom);
      i_tick  = ($urandom_range(0, 3) != 0);
      i_rst   = ($urandom_range(0, 199) == 0);
      clk_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
